// File: rtl/array_arbiter_if.sv
// Client-side bus of array_arbiter: two clients issue read/write requests
// against one shared array, and get grant/read-data pulses back.
interface array_arbiter_if #(
  parameter int WIDTH      = 12,
  parameter int INDEX_BITS = 6
);
  logic [1:0]            req;
  logic [1:0]            wr;
  logic [INDEX_BITS-1:0] idx0;
  logic [INDEX_BITS-1:0] idx1;
  logic [WIDTH-1:0]      wdata0;
  logic [WIDTH-1:0]      wdata1;
  logic [1:0]            gnt;
  logic [1:0]            rvalid;
  logic [WIDTH-1:0]      rdata;
  logic                  busy;

  // Client side: issues requests, observes grants and read data
  modport master (
    output req, wr, idx0, idx1, wdata0, wdata1,
    input  gnt, rvalid, rdata, busy
  );

  // Arbiter side
  modport slave (
    input  req, wr, idx0, idx1, wdata0, wdata1,
    output gnt, rvalid, rdata, busy
  );
endinterface

// File: rtl/array_arbiter.sv
// array_arbiter: two-client arbiter in front of a single-port array.
// One access at a time: IDLE -> WRITE -> IDLE (2 cycles) or
// IDLE -> READ -> RDATA -> IDLE (3 cycles). No request queueing.
// Optional build macro ARRAY_ARBITER_FIXED_PRIO_EN: client 0 always wins a
// dual request and the round-robin pointer is removed. Default is round-robin.
module array_arbiter #(
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 64,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  array_arbiter_if.slave        bus,
  output logic                  put,
  output logic [INDEX_BITS-1:0] p_index,
  output logic [WIDTH-1:0]      p_val,
  output logic                  get,
  output logic [INDEX_BITS-1:0] g_index,
  input  logic [WIDTH-1:0]      g_val
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  if ((1 << INDEX_BITS) < DEPTH) begin : g_depth_check
    $error("array_arbiter: INDEX_BITS too small to address DEPTH entries");
  end

  logic [1:0]            state;
  logic                  armed;   // low for the first edge after reset release
  logic                  pref;    // client preferred on a dual request
  logic                  sel;     // client chosen this cycle
  logic                  take;    // a new access is accepted this edge

  logic                  cli_p0;
  logic [INDEX_BITS-1:0] idx_p0;
  logic [WIDTH-1:0]      wdata_p0;

  // Pick a client: a lone requester always wins, a tie goes to pref
  always_comb begin
    sel = 1'b0;
    if (bus.req == 2'b11) sel = pref;
    else                  sel = bus.req[1];
  end

  assign take     = (state == S_IDLE) && armed && (bus.req != 2'b00);
  assign bus.busy = (state != S_IDLE);

`ifdef ARRAY_ARBITER_FIXED_PRIO_EN
  assign pref = 1'b0;
`else
  // Round-robin pointer: after serving a client, prefer the other one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pref <= 1'b0;
    else if (take) pref <= ~sel;
  end
`endif

  // ---- stage p0: capture the granted client's access
  // Latch the winning client's direction-independent payload
  always_ff @(posedge clk) begin
    if (take) begin
      cli_p0   <= sel;
      idx_p0   <= sel ? bus.idx1   : bus.idx0;
      wdata_p0 <= sel ? bus.wdata1 : bus.wdata0;
    end
  end

  // ---- stage p1/p2: array access and read-data return
  // Access FSM; every control output is a single-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      bus.gnt    <= 2'b00;
      bus.rvalid <= 2'b00;
      bus.rdata  <= '0;
      put        <= 1'b0;
      get        <= 1'b0;
      p_index    <= '0;
      p_val      <= '0;
      g_index    <= '0;
    end else begin
      armed      <= 1'b1;
      bus.gnt    <= 2'b00;
      bus.rvalid <= 2'b00;
      put        <= 1'b0;
      get        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take) begin
            bus.gnt <= sel ? 2'b10 : 2'b01;
            state   <= bus.wr[sel] ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          put     <= 1'b1;
          p_index <= idx_p0;
          p_val   <= wdata_p0;
          state   <= S_IDLE;
        end
        S_READ: begin
          get     <= 1'b1;
          g_index <= idx_p0;
          state   <= S_RDATA;
        end
        S_RDATA: begin
          bus.rdata  <= g_val;
          bus.rvalid <= cli_p0 ? 2'b10 : 2'b01;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_arbiter.sv
// Bench for array_arbiter: the bench also plays the array (arr) and keeps a
// transaction-level model that schedules expected pulses per cycle.
module tb_array_arbiter;
  localparam int W  = 12;
  localparam int IB = 6;
  localparam int D  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          put, get;
  logic [IB-1:0] p_index, g_index;
  logic [W-1:0]  p_val, g_val;
  logic [W-1:0]  arr [D];

  array_arbiter_if #(.WIDTH(W), .INDEX_BITS(IB)) bus ();

  array_arbiter #(.WIDTH(W), .DEPTH(D), .INDEX_BITS(IB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .put     (put),
    .p_index (p_index),
    .p_val   (p_val),
    .get     (get),
    .g_index (g_index),
    .g_val   (g_val)
  );

  always #5 clk = ~clk;

  // Array stand-in: synchronous write, combinational read
  always @(posedge clk) if (put) arr[p_index] <= p_val;
  assign g_val = arr[g_index];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [1:0]    e_gnt [8];
  logic [1:0]    e_rv  [8];
  bit            e_busy[8];
  bit            e_put [8];
  bit            e_get [8];
  logic [IB-1:0] e_pidx[8];
  logic [IB-1:0] e_gidx[8];
  logic [W-1:0]  e_pval[8];
  logic [W-1:0]  e_rd  [8];
  logic [W-1:0]  ref_mem [D];
  int            cyc = 0;
  int            next_free = 0;
  int            edges = 0;
  int            m_pref = 0;
  int            m_w;
  logic [IB-1:0] m_idx;
  logic [W-1:0]  m_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 8; s++) begin
        e_gnt[s] = 0; e_rv[s] = 0; e_busy[s] = 0; e_put[s] = 0; e_get[s] = 0;
        e_pidx[s] = 0; e_gidx[s] = 0; e_pval[s] = 0; e_rd[s] = 0;
      end
      edges = 0; next_free = 0; m_pref = 0;
    end else begin
      cyc++;
      e_gnt[(cyc+2)%8] = 0; e_rv[(cyc+2)%8] = 0; e_busy[(cyc+2)%8] = 0;
      e_put[(cyc+2)%8] = 0; e_get[(cyc+2)%8] = 0;
      if (edges < 2) edges++;
      if (edges >= 2 && cyc >= next_free && bus.req != 2'b00) begin
        if (bus.req == 2'b11) m_w = m_pref;
        else                  m_w = bus.req[1] ? 1 : 0;
        m_idx = (m_w == 1) ? bus.idx1 : bus.idx0;
        m_dat = (m_w == 1) ? bus.wdata1 : bus.wdata0;
        e_gnt[cyc%8]  = (m_w == 1) ? 2'b10 : 2'b01;
        e_busy[cyc%8] = 1;
        if (bus.wr[m_w]) begin
          e_put[(cyc+1)%8]  = 1;
          e_pidx[(cyc+1)%8] = m_idx;
          e_pval[(cyc+1)%8] = m_dat;
          ref_mem[m_idx]    = m_dat;
          next_free = cyc + 2;
        end else begin
          e_busy[(cyc+1)%8] = 1;
          e_get[(cyc+1)%8]  = 1;
          e_gidx[(cyc+1)%8] = m_idx;
          e_rv[(cyc+2)%8]   = (m_w == 1) ? 2'b10 : 2'b01;
          e_rd[(cyc+2)%8]   = ref_mem[m_idx];
          next_free = cyc + 3;
        end
`ifndef ARRAY_ARBITER_FIXED_PRIO_EN
        m_pref = 1 - m_w;
`endif
      end
    end
  end

  // Compare DUT outputs against the model every cycle, mid-period
  always @(negedge clk) begin
    chk("gnt",    bus.gnt,    e_gnt[cyc%8]);
    chk("rvalid", bus.rvalid, e_rv[cyc%8]);
    chk("busy",   bus.busy,   e_busy[cyc%8]);
    chk("put",    put,        e_put[cyc%8]);
    chk("get",    get,        e_get[cyc%8]);
    if (e_put[cyc%8]) begin
      chk("p_index", p_index, e_pidx[cyc%8]);
      chk("p_val",   p_val,   e_pval[cyc%8]);
    end
    if (e_get[cyc%8])        chk("g_index", g_index, e_gidx[cyc%8]);
    if (e_rv[cyc%8] != 2'b00) chk("rdata",  bus.rdata, e_rd[cyc%8]);
    if (!rst_n) begin
      chk("rst_rdata",   bus.rdata, 0);
      chk("rst_p_index", p_index,   0);
      chk("rst_p_val",   p_val,     0);
      chk("rst_g_index", g_index,   0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_access(input int c, input bit w, input logic [IB-1:0] i,
                           input logic [W-1:0] d, output logic [1:0] rv,
                           output logic [W-1:0] rd);
    bit got = 0;
    bus.req[c] = 1'b1;
    bus.wr[c]  = w;
    if (c == 0) begin bus.idx0 = i; bus.wdata0 = d; end
    else        begin bus.idx1 = i; bus.wdata1 = d; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.gnt[c]) begin got = 1; break; end
    end
    bus.req[c] = 1'b0;
    chk("access_grant", got, 1);
    if (w) @(negedge clk);
    else   repeat (2) @(negedge clk);
    rv = bus.rvalid;
    rd = bus.rdata;
  endtask

  logic [W-1:0] vals [4];
  logic [1:0]   gseq [3];
  logic [1:0]   rvseq [2];
  logic [W-1:0] rdseq [2];
  logic [1:0]   rv;
  logic [W-1:0] rd;
  int           ng, nr, cnt;

  initial begin
    vals[0] = 12'd55; vals[1] = 12'd30; vals[2] = 12'd4095; vals[3] = 12'd0;
    for (int i = 0; i < D; i++) begin arr[i] = '0; ref_mem[i] = '0; end
    rst_n = 1'b0;
    bus.req = 2'b00; bus.wr = 2'b00;
    bus.idx0 = '0; bus.idx1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", bus.gnt, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_put_get", {put, get}, 0);
    chk("reset_rvalid", bus.rvalid, 0);

    // Request pending across reset release: grant on the second edge
    bus.req = 2'b01; bus.wr = 2'b01; bus.idx0 = 6'd10; bus.wdata0 = 12'd7;
    rst_n = 1'b1;
    @(negedge clk); chk("first_edge_gnt", bus.gnt, 2'b00);
    @(negedge clk); chk("second_edge_gnt", bus.gnt, 2'b01); bus.req = 2'b00;
    @(negedge clk); chk("rel_put", put, 1); chk("rel_p_index", p_index, 10);
    @(negedge clk);

    // Client 0 write idx 5 = 55
    bus.req = 2'b01; bus.wr = 2'b01; bus.idx0 = 6'd5; bus.wdata0 = 12'd55;
    @(negedge clk); chk("w5_gnt", bus.gnt, 2'b01); chk("w5_busy", bus.busy, 1); bus.req = 2'b00;
    @(negedge clk); chk("w5_put", put, 1); chk("w5_p_index", p_index, 5);
    chk("w5_p_val", p_val, 55); chk("w5_busy_after", bus.busy, 0);
    @(negedge clk); chk("w5_put_drop", put, 0);

    // Client 1 read idx 5
    bus.req = 2'b10; bus.wr = 2'b00; bus.idx1 = 6'd5;
    @(negedge clk); chk("r5_gnt", bus.gnt, 2'b10); bus.req = 2'b00;
    @(negedge clk); chk("r5_get", get, 1); chk("r5_g_index", g_index, 5); chk("r5_put", put, 0);
    @(negedge clk); chk("r5_rvalid", bus.rvalid, 2'b10); chk("r5_rdata", bus.rdata, 55);
    chk("r5_busy", bus.busy, 0);

    // A request raised and dropped while busy is discarded
    bus.req = 2'b01; bus.wr = 2'b00; bus.idx0 = 6'd10;
    @(negedge clk); chk("busy_gnt", bus.gnt, 2'b01);
    bus.req = 2'b10; bus.wr = 2'b10; bus.idx1 = 6'd7; bus.wdata1 = 12'd99;
    @(negedge clk); bus.req = 2'b00;
    @(negedge clk); chk("busy_rvalid", bus.rvalid, 2'b01); chk("busy_rdata", bus.rdata, 7);
    cnt = 0;
    repeat (3) begin @(negedge clk); if (bus.gnt[1]) cnt++; end
    chk("dropped_req_gnt", cnt, 0);
    chk("dropped_req_arr", arr[7], 0);

    // Preload idx 2/3 via client 1, then both clients read continuously
    do_access(1, 1'b1, 6'd2, 12'd4095, rv, rd);
    do_access(1, 1'b1, 6'd3, 12'd0, rv, rd);
    bus.req = 2'b11; bus.wr = 2'b00; bus.idx0 = 6'd2; bus.idx1 = 6'd3;
    ng = 0; nr = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00 && ng < 3) begin gseq[ng] = bus.gnt; ng++; end
      if (bus.rvalid != 2'b00 && nr < 2) begin rvseq[nr] = bus.rvalid; rdseq[nr] = bus.rdata; nr++; end
    end
    bus.req = 2'b00;
    chk("dual_ngrants", ng, 3);
    chk("dual_g0", gseq[0], 2'b01);
`ifdef ARRAY_ARBITER_FIXED_PRIO_EN
    chk("dual_g1", gseq[1], 2'b01);
    chk("dual_rv1", rvseq[1], 2'b01);
    chk("dual_rd1", rdseq[1], 4095);
`else
    chk("dual_g1", gseq[1], 2'b10);
    chk("dual_rv1", rvseq[1], 2'b10);
    chk("dual_rd1", rdseq[1], 0);
`endif
    chk("dual_g2", gseq[2], 2'b01);
    chk("dual_rv0", rvseq[0], 2'b01);
    chk("dual_rd0", rdseq[0], 4095);
    repeat (2) @(negedge clk);

    // Sweep all indices, then read everything back and wrap to 0
    for (int i = 0; i < D; i++)
      do_access(i % 2, 1'b1, i[IB-1:0], vals[i%4], rv, rd);
    for (int i = 0; i < D; i++) begin
      do_access((i + 1) % 2, 1'b0, i[IB-1:0], 12'd0, rv, rd);
      chk("sweep_rvalid", rv, ((i + 1) % 2 == 1) ? 2'b10 : 2'b01);
      chk("sweep_rdata", rd, vals[i%4]);
    end
    do_access(0, 1'b0, 6'd0, 12'd0, rv, rd);
    chk("wrap_rdata", rd, 55);

    // Reset while the read is in flight aborts it
    bus.req = 2'b01; bus.wr = 2'b00; bus.idx0 = 6'd5;
    @(negedge clk); chk("abort_gnt", bus.gnt, 2'b01); bus.req = 2'b00;
    @(negedge clk); chk("abort_get_before", get, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_get", get, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rvalid", bus.rvalid, 0);
    chk("abort_rdata", bus.rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin @(negedge clk); if (bus.rvalid != 2'b00) cnt++; end
    chk("abort_no_rvalid", cnt, 0);
    do_access(0, 1'b0, 6'd5, 12'd0, rv, rd);
    chk("post_abort_rdata", rd, 30);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
